// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU write-back
// (port A) and the load unit (port B) with round-robin arbitration.
// Keeps a busy bit per architectural register so issue can detect RAW
// hazards on rs1/rs2. The write toward the register file is registered
// (1-cycle latency). A saturating counter records cycles where both
// producers competed for the port.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  // ALU write-back request
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  // load write-back request
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  // register-file write port
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  // scoreboard
  input  logic              issue_set,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  // statistics
  output logic [CNT_W-1:0]  conflict_cnt
);

  // 1 = port B was granted most recently. Reset to B so A wins the first tie.
  logic                last_grant_b_reg;

  // Combinational arbitration results
  logic                grant_a;
  logic                grant_b;
  logic                accept;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;

  // Registered write stage
  logic                rf_we_reg;
  logic [ADDR_W-1:0]   rf_rd_reg;
  logic [DATA_W-1:0]   rf_wdata_reg;

  // Scoreboard: one pending-write bit per architectural register
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Conflict counter
  logic [CNT_W-1:0]    conflict_cnt_reg;
  logic                conflict;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------

  // Round-robin grant: a lone requester always wins; on a tie the port
  // that did not win last time gets the write port.
  always_comb begin
    grant_a  = a_valid & (~b_valid | last_grant_b_reg);
    grant_b  = b_valid & ~grant_a;
    accept   = grant_a | grant_b;
    sel_rd   = grant_a ? a_rd   : b_rd;
    sel_data = grant_a ? a_data : b_data;
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign conflict = a_valid & b_valid;

  // Remember the winner, but only on cycles where something was accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_b_reg <= 1'b1;
    end else if (accept) begin
      last_grant_b_reg <= grant_b;
    end
  end

  // ---------------------------------------------------------------------
  // Registered write stage
  // ---------------------------------------------------------------------

  // Capture the accepted request; x0 completes its handshake but never
  // raises the write enable. Destination and data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_reg    <= 1'b0;
      rf_rd_reg    <= '0;
      rf_wdata_reg <= '0;
    end else if (accept) begin
      rf_we_reg    <= (sel_rd != '0);
      rf_rd_reg    <= sel_rd;
      rf_wdata_reg <= sel_data;
    end else begin
      rf_we_reg    <= 1'b0;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_rd    = rf_rd_reg;
  assign rf_wdata = rf_wdata_reg;

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------

  // Per-register next state. The set term is ORed after the clear so a
  // newer producer issued on the same edge as an older commit keeps the
  // register busy. Register 0 is never busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit       = issue_set & (issue_rd == ADDR_W'(gi));
        assign clr_hit       = rf_we_reg & (rf_rd_reg == ADDR_W'(gi));
        assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  // Scoreboard state; flushed together with the pipeline on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Hazard queries: a register is busy if its scoreboard bit is set or the
  // write stage is committing to it right now. x0 never reports a hazard.
  always_comb begin
    rs1_busy = (rs1 != '0) & (busy_reg[rs1] | (rf_we_reg & (rf_rd_reg == rs1)));
    rs2_busy = (rs2 != '0) & (busy_reg[rs2] | (rf_we_reg & (rf_rd_reg == rs2)));
  end

  // ---------------------------------------------------------------------
  // Conflict counter
  // ---------------------------------------------------------------------

  // Count tie cycles, saturating at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_reg <= '0;
    end else if (conflict && !(&conflict_cnt_reg)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: the driver computes per-cycle
// expectations from a behavioural model and queues them; a monitor pops
// one expectation per cycle on the falling edge and compares.
// A narrow conflict counter is used so saturation is reached quickly.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd, rf_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic          rf_we, issue_set, rs1_busy, rs2_busy;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic          ar;
    logic          br;
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
    logic          r1b;
    logic          r2b;
    int            cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model state
  bit            m_last_b;     // port B won the most recent grant
  bit            m_busy[NR];   // registers with a pending producer
  bit            m_we;         // a write is visible at the port this cycle
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;
  int            m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_last_b = 1'b1;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_we  = 1'b0;
    m_rd  = '0;
    m_wd  = '0;
    m_cnt = 0;
  endtask

  // Apply one cycle of stimulus, queue its expectation, advance the model.
  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
                       input logic iset, input logic [AW-1:0] ird,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    exp_t e;
    logic ga, gb;
    @(posedge clk);
    #1;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    issue_set = iset; issue_rd = ird;
    rs1 = r1; rs2 = r2;
    if (av && bv) begin
      ga = m_last_b;
      gb = !m_last_b;
    end else begin
      ga = av;
      gb = bv;
    end
    e.ar  = ga;
    e.br  = gb;
    e.we  = m_we;
    e.rd  = m_rd;
    e.wd  = m_wd;
    e.r1b = (r1 != 0) && (m_busy[r1] || (m_we && m_rd == r1));
    e.r2b = (r2 != 0) && (m_busy[r2] || (m_we && m_rd == r2));
    e.cnt = m_cnt;
    exp_q.push_back(e);
    // state after the coming edge
    if (av && bv && m_cnt < CMAX) m_cnt++;
    if (m_we) m_busy[m_rd] = 1'b0;
    if (iset && ird != 0) m_busy[ird] = 1'b1;
    if (ga || gb) begin
      m_last_b = gb;
      m_rd     = ga ? ard : brd;
      m_wd     = ga ? ad : bd;
      m_we     = (m_rd != 0);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_ready", 64'(a_ready), 64'(e.ar));
        chk("b_ready", 64'(b_ready), 64'(e.br));
        chk("rf_we", 64'(rf_we), 64'(e.we));
        if (e.we) begin
          chk("rf_rd", 64'(rf_rd), 64'(e.rd));
          chk("rf_wdata", rf_wdata, e.wd);
        end
        chk("rs1_busy", 64'(rs1_busy), 64'(e.r1b));
        chk("rs2_busy", 64'(rs2_busy), 64'(e.r2b));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
        if (e.ar || e.br || e.we)
          $display("cyc %0d a_ready=%0b b_ready=%0b rf_we=%0b rf_rd=%0d rf_wdata=%h cnt=%0d",
                   cyc, a_ready, b_ready, rf_we, rf_rd, rf_wdata, conflict_cnt);
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    issue_set = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_rf_rd", 64'(rf_rd), 64'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    rst = 1'b1;

    // A alone, then the registered write, then idle
    drive(1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // four tie cycles
    for (int i = 0; i < 4; i++)
      drive(1, AW'(1 + i), {$urandom, $urandom}, 1, AW'(9 + i), {$urandom, $urandom}, 0, 0, 1, 9);
    idle(1, 9);
    idle(0, 0);

    // scoreboard set, then clear by a load write to x7
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    drive(0, 0, 0, 1, 7, 64'h7777, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // same-edge set and clear on x3; issue to x0 never marks busy
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    drive(0, 0, 0, 1, 3, 64'h3333, 0, 0, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    idle(3, 0);

    // write to x0: handshake only
    drive(1, 0, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // drive the conflict counter into saturation
    for (int i = 0; i < CMAX + 3; i++)
      drive(1, AW'($urandom_range(1, NR - 1)), {$urandom, $urandom},
            1, AW'($urandom_range(1, NR - 1)), {$urandom, $urandom}, 0, 0, 0, 0);
    idle(0, 0);

    // asynchronous reset while a write is in flight
    drive(0, 0, 0, 0, 0, 0, 1, 13, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 14, 0, 0);
    drive(1, 12, 64'hABCD, 0, 0, 0, 1, 12, 0, 0);
    idle(12, 13);
    @(negedge clk);
    #1;
    chk("pre_reset_rf_we", 64'(rf_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rf_we", 64'(rf_we), 64'd0);
    chk("async_rf_rd", 64'(rf_rd), 64'd0);
    chk("async_rf_wdata", rf_wdata, 64'd0);
    chk("async_cnt", 64'(conflict_cnt), 64'd0);
    for (int i = 1; i < NR; i++) begin
      rs1 = AW'(i);
      #1;
      chk("async_busy", 64'(rs1_busy), 64'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom));
    idle(0, 0);
    idle(0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
